// File: rtl/word_streamer_pkg.sv
// Shared constants and sizing helpers for the word_streamer
// serial-to-parallel deserializer.
package word_streamer_pkg;

  localparam bit ORDER_MSB_FIRST = 1'b0;
  localparam bit ORDER_LSB_FIRST = 1'b1;

  // Bits needed to hold any value in 0..n
  function automatic int cnt_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/word_streamer_fifo.sv
// First-word-fall-through FIFO holding completed words.
// Pointers carry one extra wrap bit to tell full from empty.
module word_streamer_fifo
  import word_streamer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 pop_data,
  output logic                             empty,
  output logic                             full,
  output logic [cnt_bits(FIFO_DEPTH)-1:0]  level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = cnt_bits(FIFO_DEPTH);
  localparam logic [AW:0] PONE = 1;

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // Popping frees the slot, so a full FIFO still takes a push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PONE;
    if (do_pop)  rd_d = rd_q + PONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign level    = LW'(wr_q - rd_q);

endmodule

// File: rtl/word_streamer.sv
// Serial-in / parallel-out deserializer with selectable bit
// order and a small FWFT output buffer.
module word_streamer
  import word_streamer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = ORDER_MSB_FIRST,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             shift_enable,
  input  logic                             serial_in,
  input  logic                             flush,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [cnt_bits(WIDTH)-1:0]       bit_count,
  output logic [cnt_bits(FIFO_DEPTH)-1:0]  fifo_level,
  output logic                             overflow,
  input  logic                             clear_overflow
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] CONE  = 1;
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic             push, pop, drop;
  logic             full, empty;

  always_comb begin
    if (LSB_FIRST == ORDER_LSB_FIRST)
      shifted = {serial_in, sr_q[WIDTH-1:1]};
    else
      shifted = {sr_q[WIDTH-2:0], serial_in};
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    if (flush) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (shift_enable) begin
      sr_d = shifted;
      if (cnt_q == CLAST) begin
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CONE;
      end
    end
  end

  assign pop  = !empty && out_ready;
  assign drop = push && full && !pop;

  // A drop on the same edge as a clear must stay visible
  always_comb begin
    ov_d = ov_q;
    if (clear_overflow) ov_d = 1'b0;
    if (drop)           ov_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
    end
  end

  word_streamer_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (shifted),
    .pop       (pop),
    .pop_data  (out_data),
    .empty     (empty),
    .full      (full),
    .level     (fifo_level)
  );

  assign out_valid = !empty;
  assign bit_count = cnt_q;
  assign overflow  = ov_q;

endmodule

// File: tb/tb_word_streamer.sv
// Directed bench: one MSB-first and one LSB-first instance share
// stimulus; a queue per instance scoreboards emitted words.
module tb_word_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_enable = 1'b0;
  logic       serial_in = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic       clear_overflow = 1'b0;

  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic [3:0] m_cnt, l_cnt;
  logic [2:0] m_lvl, l_lvl;
  logic       m_ov, l_ov;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] qm[$];
  logic [7:0] ql[$];

  always #5 clk = ~clk;

  word_streamer #(.WIDTH(8), .LSB_FIRST(1'b0), .FIFO_DEPTH(4)) u_m (
    .clk(clk), .rst(rst), .shift_enable(shift_enable),
    .serial_in(serial_in), .flush(flush), .out_data(m_data),
    .out_valid(m_valid), .out_ready(out_ready), .bit_count(m_cnt),
    .fifo_level(m_lvl), .overflow(m_ov),
    .clear_overflow(clear_overflow)
  );

  word_streamer #(.WIDTH(8), .LSB_FIRST(1'b1), .FIFO_DEPTH(4)) u_l (
    .clk(clk), .rst(rst), .shift_enable(shift_enable),
    .serial_in(serial_in), .flush(flush), .out_data(l_data),
    .out_valid(l_valid), .out_ready(out_ready), .bit_count(l_cnt),
    .fifo_level(l_lvl), .overflow(l_ov),
    .clear_overflow(clear_overflow)
  );

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic se, input logic b, input logic fl);
    shift_enable = se;
    serial_in    = b;
    flush        = fl;
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
    serial_in    = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] w, input bit keep);
    if (keep) begin
      qm.push_back(w);
      ql.push_back(rev8(w));
    end
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0);
  endtask

  // Scoreboard: a word is consumed on the edge after this sample
  always @(negedge clk) begin
    if (!rst && m_valid && out_ready) begin
      if (qm.size() == 0) chk("m_stray_word", {24'd0, m_data}, 32'hDEAD);
      else chk("m_word", {24'd0, m_data}, {24'd0, qm.pop_front()});
    end
    if (!rst && l_valid && out_ready) begin
      if (ql.size() == 0) chk("l_stray_word", {24'd0, l_data}, 32'hDEAD);
      else chk("l_word", {24'd0, l_data}, {24'd0, ql.pop_front()});
    end
  end

  initial begin
    logic [7:0] w;
    #3;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_cnt", 32'(m_cnt), 32'd0);
    chk("rst_lvl", 32'(m_lvl), 32'd0);
    chk("rst_ov", 32'(m_ov), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic word, both bit orders; visible one cycle after last bit
    w = 8'hA6;
    qm.push_back(w);
    ql.push_back(rev8(w));
    for (int i = 7; i >= 1; i--) step(1'b1, w[i], 1'b0);
    chk("pre_last_valid", 32'(m_valid), 32'd0);
    step(1'b1, w[0], 1'b0);
    chk("msb_valid", 32'(m_valid), 32'd1);
    chk("msb_data", 32'(m_data), 32'hA6);
    chk("lsb_data", 32'(l_data), 32'h65);
    chk("cnt_wrap", 32'(m_cnt), 32'd0);
    idle(1);
    chk("valid_one_cycle", 32'(m_valid), 32'd0);

    // Gap of three idle cycles mid-word
    qm.push_back(w);
    ql.push_back(rev8(w));
    for (int i = 7; i >= 4; i--) step(1'b1, w[i], 1'b0);
    for (int g = 0; g < 3; g++) begin
      idle(1);
      chk("gap_cnt_hold", 32'(m_cnt), 32'd4);
    end
    for (int i = 3; i >= 0; i--) step(1'b1, w[i], 1'b0);
    chk("gap_data", 32'(m_data), 32'hA6);
    idle(2);

    // Overflow: five words into a four-deep buffer
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(8'(k), k <= 4);
    chk("ovf_lvl", 32'(m_lvl), 32'd4);
    chk("ovf_flag", 32'(m_ov), 32'd1);
    chk("ovf_head_stable", 32'(m_data), 32'h01);
    out_ready = 1'b1;
    idle(6);
    chk("drain_lvl", 32'(m_lvl), 32'd0);
    chk("drain_q_empty", 32'(qm.size()), 32'd0);
    chk("ovf_sticky", 32'(m_ov), 32'd1);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    chk("ovf_cleared", 32'(m_ov), 32'd0);

    // Flush beats a simultaneous shift
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("pre_flush_cnt", 32'(m_cnt), 32'd3);
    step(1'b1, 1'b1, 1'b1);
    chk("flush_cnt", 32'(m_cnt), 32'd0);
    send(8'h3C, 1'b1);
    chk("flush_word", 32'(m_data), 32'h3C);
    idle(2);
    chk("flush_no_stray", 32'(m_valid), 32'd0);

    // Reset mid-word with words buffered
    out_ready = 1'b0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("pre_rst_lvl", 32'(m_lvl), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_lvl", 32'(m_lvl), 32'd0);
    chk("arst_cnt", 32'(m_cnt), 32'd0);
    chk("arst_ov", 32'(m_ov), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'hFF, 1'b1);
    chk("post_rst_word", 32'(m_data), 32'hFF);
    idle(3);

    chk("end_qm_empty", 32'(qm.size()), 32'd0);
    chk("end_ql_empty", 32'(ql.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/word_streamer.md
Name: word_streamer

Overview:
Parametrised serial-in/parallel-out deserializer; generalises the 8-bit byte shifter to arbitrary word width with selectable bit order.
- Counts incoming bits and emits each completed word through a valid/ready output port.
- Completed words are buffered in a small FWFT FIFO, so the downstream consumer may stall without losing data until the buffer fills.
- Sits between a serial link front-end and the word-oriented datapath.

Parameters:
WIDTH, 8, bits per assembled word (>=2)
LSB_FIRST, 0, 0 = first received bit lands in MSB; 1 = first received bit lands in LSB
FIFO_DEPTH, 4, output buffer depth in words (power of 2, >=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
shift_enable  in  1  sample serial_in on this edge
serial_in  in  1  serial data bit
flush  in  1  discard partially assembled word
out_data  out  WIDTH  head-of-FIFO word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data this cycle
bit_count  out  $clog2(WIDTH+1)  bits held in the partial word (0..WIDTH-1)
fifo_level  out  $clog2(FIFO_DEPTH+1)  words buffered (0..FIFO_DEPTH)
overflow  out  1  sticky: a completed word was dropped
clear_overflow  in  1  clears overflow

Behaviour:
- Reset (async, immediate): shift register, bit_count, FIFO pointers, fifo_level and overflow all go to 0. out_valid=0 and out_data=0. Reset mid-word discards the partial word and all buffered words.
- Shift, on a clk edge with shift_enable=1 and flush=0:
  - MSB-first: sr <= {sr[WIDTH-2:0], serial_in}.
  - LSB-first: sr <= {serial_in, sr[WIDTH-1:1]}.
  - bit_count increments.
- shift_enable=0: sr and bit_count hold. Gaps of any length between bits are legal.
- Word completion: on a shift edge with bit_count==WIDTH-1:
  - The assembled word, including the current serial_in, is pushed to the FIFO on that edge.
  - bit_count returns to 0.
  - Latency: out_valid/out_data reflect the word in the cycle after the edge that sampled the last bit, when the FIFO was empty.
- Output handshake:
  - Pop occurs on an edge where out_valid && out_ready.
  - out_data is first-word-fall-through, and is stable while out_valid=1 and out_ready=0.
  - out_ready is ignored when out_valid=0.
- Full FIFO, push with no pop on the same edge: the word is dropped, overflow is set, and fifo_level stays at FIFO_DEPTH.
- Full FIFO, push and pop on the same edge: both occur, no overflow, and the level stays at FIFO_DEPTH.
- Empty FIFO, push and pop on the same edge: the pop is not possible (out_valid=0). The push lands and the level becomes 1.
- flush=1: sr and bit_count clear on the edge. Flush has priority over a simultaneous shift_enable, and that bit is discarded. Flush does not affect FIFO contents.
- clear_overflow=1: overflow clears. If a drop occurs on the same edge, set wins and overflow=1.
- Pointer wrap: pointers have log2(FIFO_DEPTH)+1 bits and the extra MSB distinguishes full from empty. Wrap-around must preserve word order.

Decomposition:
- Shared package word_streamer_pkg holds:
  - Bit-order constants ORDER_MSB_FIRST=0 and ORDER_LSB_FIRST=1.
  - A width-helper function for the counter and level sizes.
- One sub-module, word_streamer_fifo:
  - Parametrised synchronous FWFT FIFO (WIDTH, FIFO_DEPTH).
  - Ports: push, push_data, pop, pop_data, empty, full, level.
  - Async active-high reset.
- The top level holds the shift register, bit counter and overflow logic.

Test Plan:
- WIDTH=8, MSB-first, out_ready=1; shift bits 1,0,1,0,0,1,1,0 on consecutive edges -> out_valid=1 for one cycle, one cycle after the 8th bit, with out_data=0xA6; bit_count returns to 0.
- LSB_FIRST=1, same bit sequence -> out_data=0x65.
- MSB-first, same 8 bits with shift_enable deasserted for 3 cycles between bits 4 and 5 -> out_data=0xA6; bit_count holds 4 during the gap.
- FIFO_DEPTH=4, out_ready=0; send 5 words 0x01..0x05 -> fifo_level=4 and overflow=1. Then raise out_ready -> pops return 0x01,0x02,0x03,0x04 in order, and 0x05 is absent.
- Shift 3 bits 1,1,1, pulse flush with shift_enable=1, then shift 0x3C MSB-first -> out_data=0x3C, and no stray word is emitted.
- Buffer 2 words, assert rst mid-way through a third word -> out_valid, fifo_level, bit_count and overflow are all 0 immediately. A subsequent full byte 0xFF emerges as 0xFF.
